hl2link_tx: RTL and testbench

//  Transmit half of the hl2link board-to-board link.
//  - Accepts one 38-bit word plus a 2-bit type tag over a valid/ready stream (send_* side of the link).
//  - Serializes it as a framed, parity-protected sequence of 2-bit symbols on linktx.
//  - Sits between the link application layer (command / sample mux) and the I/O pins.
//  - Its frames are decoded by the hl2link receive half on the partner board.

---
 rtl/hl2link_tx.sv | 236 +++++++++++++++++++++++
 tb/tb_hl2link_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hl2link_tx.sv
// ----------------------------------------------------------------------------
// hl2link_tx
//
// Transmit half of the hl2link board-to-board link. One 38-bit word plus a
// 2-bit type tag is taken over a valid/ready stream. It is sent on linktx as
// a framed sequence of 23 two-bit symbols, each held CLKS_PER_SYM clocks:
//
//   SOF0=11, SOF1=10, USER=tuser, D0..D18 (tdata MSB first), PAR
//
// PAR holds even parity per lane over USER and D0..D18. After every frame,
// including an aborted one, the line is held idle (00) for GAP_SYMS symbols.
//
// Parameters
//   CLKS_PER_SYM  clocks each symbol is held on linktx (>= 1)
//   GAP_SYMS      idle symbols forced after every frame (>= 0)
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst          in   1   synchronous active-high reset
//   link_up      in   1   link established; frames only start while high
//   send_tvalid  in   1   word available
//   send_tdata   in  38   payload, sent MSB first
//   send_tuser   in   2   frame type, passed through unmodified
//   send_tready  out  1   word accepted on this edge if send_tvalid is high
//   send_tdone   out  1   one-cycle pulse in the last PAR cycle
//   linktx       out  2   registered symbol output to the pins
//   busy         out  1   high from accept until the end of the gap
//
// FSM states
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | line idle (00); ready when link_up is high
//   SOF0    | first start-of-frame symbol (11) on the line
//   SOF1    | second start-of-frame symbol (10) on the line
//   USER    | captured tuser on the line
//   DATA    | payload symbols D0..D18, r_idx selects which one
//   PAR     | per-lane parity symbol on the line
//   GAP     | forced idle (00) symbols, r_idx counts them
// ----------------------------------------------------------------------------
module hl2link_tx #(
    parameter int CLKS_PER_SYM = 4,
    parameter int GAP_SYMS     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        link_up,
    input  logic        send_tvalid,
    input  logic [37:0] send_tdata,
    input  logic [1:0]  send_tuser,
    output logic        send_tready,
    output logic        send_tdone,
    output logic [1:0]  linktx,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF0,
        ST_SOF1,
        ST_USER,
        ST_DATA,
        ST_PAR,
        ST_GAP
    } state_t;

    localparam int DW = (CLKS_PER_SYM > 1) ? $clog2(CLKS_PER_SYM) : 1;
    localparam int IW = (GAP_SYMS > 19) ? $clog2(GAP_SYMS) + 1 : 5;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLKS_PER_SYM - 1);
    localparam logic [DW-1:0] DIV_PEN   = DW'((CLKS_PER_SYM > 1) ? CLKS_PER_SYM - 2 : 0);
    localparam logic [IW-1:0] DATA_LAST = IW'(18);
    localparam logic [IW-1:0] GAP_LAST  = IW'((GAP_SYMS > 0) ? GAP_SYMS - 1 : 0);

    localparam bit ONE_CLK = (CLKS_PER_SYM == 1);
    localparam bit HAS_GAP = (GAP_SYMS > 0);

    localparam logic [1:0] SYM_IDLE = 2'b00;
    localparam logic [1:0] SYM_SOF0 = 2'b11;
    localparam logic [1:0] SYM_SOF1 = 2'b10;

    state_t        r_state;
    logic [DW-1:0] r_div;
    logic [IW-1:0] r_idx;
    logic [37:0]   r_data;
    logic [1:0]    r_user;
    logic [1:0]    r_par;
    logic [1:0]    r_linktx;
    logic          r_tdone;
    logic          r_busy;
    logic          r_armed;

    wire w_sym_end = (r_div == DIV_LAST);

    // Frame states that a falling link_up must abort.
    wire w_in_frame = (r_state == ST_SOF0) || (r_state == ST_SOF1) ||
                      (r_state == ST_USER) || (r_state == ST_DATA) ||
                      (r_state == ST_PAR);

    // r_armed keeps tready low for the first cycle after reset, so the
    // reset cycle itself shows all outputs at zero even with link_up high.
    wire w_ready  = (r_state == ST_IDLE) && link_up && r_armed;
    wire w_accept = send_tvalid && w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_div    <= '0;
            r_idx    <= '0;
            r_data   <= '0;
            r_user   <= '0;
            r_par    <= '0;
            r_linktx <= SYM_IDLE;
            r_tdone  <= 1'b0;
            r_busy   <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            r_tdone <= 1'b0;
            r_div   <= w_sym_end ? '0 : r_div + DW'(1);

            if (w_in_frame && !link_up) begin
                // Abort: drop to idle symbols at once, still honour the gap.
                r_div    <= '0;
                r_idx    <= '0;
                r_linktx <= SYM_IDLE;
                if (HAS_GAP) begin
                    r_state <= ST_GAP;
                    r_busy  <= 1'b1;
                end else begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_div    <= '0;
                        r_linktx <= SYM_IDLE;
                        if (w_accept) begin
                            r_state  <= ST_SOF0;
                            r_data   <= send_tdata;
                            r_user   <= send_tuser;
                            // Parity seeds with USER; data lanes fold in as loaded.
                            r_par    <= send_tuser;
                            r_linktx <= SYM_SOF0;
                            r_busy   <= 1'b1;
                        end
                    end

                    ST_SOF0: begin
                        if (w_sym_end) begin
                            r_state  <= ST_SOF1;
                            r_linktx <= SYM_SOF1;
                        end
                    end

                    ST_SOF1: begin
                        if (w_sym_end) begin
                            r_state  <= ST_USER;
                            r_linktx <= r_user;
                        end
                    end

                    ST_USER: begin
                        if (w_sym_end) begin
                            r_state  <= ST_DATA;
                            r_idx    <= '0;
                            r_linktx <= r_data[37:36];
                            r_par    <= r_par ^ r_data[37:36];
                            r_data   <= {r_data[35:0], 2'b00};
                        end
                    end

                    ST_DATA: begin
                        if (w_sym_end) begin
                            if (r_idx == DATA_LAST) begin
                                // r_par already includes D18, folded in when it was loaded.
                                r_state  <= ST_PAR;
                                r_linktx <= r_par;
                                if (ONE_CLK) begin
                                    r_tdone <= 1'b1;
                                end
                            end else begin
                                r_idx    <= r_idx + IW'(1);
                                r_linktx <= r_data[37:36];
                                r_par    <= r_par ^ r_data[37:36];
                                r_data   <= {r_data[35:0], 2'b00};
                            end
                        end
                    end

                    ST_PAR: begin
                        // tdone is registered, so it is set one clock early to
                        // land on the last PAR cycle.
                        if (!ONE_CLK && (r_div == DIV_PEN)) begin
                            r_tdone <= 1'b1;
                        end
                        if (w_sym_end) begin
                            r_linktx <= SYM_IDLE;
                            r_idx    <= '0;
                            if (HAS_GAP) begin
                                r_state <= ST_GAP;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end

                    ST_GAP: begin
                        r_linktx <= SYM_IDLE;
                        if (w_sym_end) begin
                            if (r_idx == GAP_LAST) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_idx <= r_idx + IW'(1);
                            end
                        end
                    end

                    default: begin
                        r_state  <= ST_IDLE;
                        r_linktx <= SYM_IDLE;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign send_tready = w_ready;
    assign send_tdone  = r_tdone;
    assign linktx      = r_linktx;
    assign busy        = r_busy;

endmodule

// File: tb/tb_hl2link_tx.sv
// ----------------------------------------------------------------------------
// tb_hl2link_tx
//
// Bench for hl2link_tx. Three instances cover the parameter corners:
//   0: CLKS_PER_SYM=1, GAP_SYMS=2
//   1: CLKS_PER_SYM=4, GAP_SYMS=2
//   2: CLKS_PER_SYM=1, GAP_SYMS=0
// Each accepted word is pushed to a scoreboard queue; the frame seen on
// linktx is decoded, popped against it, and its parity checked against a
// per-lane XOR model. Outputs are sampled and inputs driven on the falling
// edge.
// ----------------------------------------------------------------------------
module tb_hl2link_tx;

    typedef struct packed {
        logic [1:0]  user;
        logic [37:0] data;
    } frm_t;

    logic        clk;
    logic        rst;
    logic        lu [3];
    logic        tv [3];
    logic [37:0] td [3];
    logic [1:0]  tu [3];
    wire         tr [3];
    wire         dn [3];
    wire         bz [3];
    wire  [1:0]  tx [3];

    int   n_cmp;
    int   n_mis;
    int   cyc;
    frm_t sb [$];

    hl2link_tx #(.CLKS_PER_SYM(1), .GAP_SYMS(2)) u_dut0 (
        .clk(clk), .rst(rst), .link_up(lu[0]), .send_tvalid(tv[0]),
        .send_tdata(td[0]), .send_tuser(tu[0]), .send_tready(tr[0]),
        .send_tdone(dn[0]), .linktx(tx[0]), .busy(bz[0])
    );

    hl2link_tx #(.CLKS_PER_SYM(4), .GAP_SYMS(2)) u_dut1 (
        .clk(clk), .rst(rst), .link_up(lu[1]), .send_tvalid(tv[1]),
        .send_tdata(td[1]), .send_tuser(tu[1]), .send_tready(tr[1]),
        .send_tdone(dn[1]), .linktx(tx[1]), .busy(bz[1])
    );

    hl2link_tx #(.CLKS_PER_SYM(1), .GAP_SYMS(0)) u_dut2 (
        .clk(clk), .rst(rst), .link_up(lu[2]), .send_tvalid(tv[2]),
        .send_tdata(td[2]), .send_tuser(tu[2]), .send_tready(tr[2]),
        .send_tdone(dn[2]), .linktx(tx[2]), .busy(bz[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [1:0] model_par(input logic [1:0] u, input logic [37:0] d);
        logic [1:0] p;
        p = u;
        for (int i = 0; i < 19; i++) begin
            p = p ^ d[37-2*i -: 2];
        end
        return p;
    endfunction

    // Returns at a falling edge where tvalid and tready are both high, so
    // the word is taken on the next rising edge.
    task automatic wait_accept(input int inst, input int limit, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            if (tv[inst] && tr[inst]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
    endtask

    // Called at the accept falling edge; walks the frame and the gap.
    task automatic run_frame(input int inst, input int cps, input int gap,
                             input bit hold_valid, input int pulse_at);
        logic [1:0]  sym [23];
        logic [37:0] dec;
        frm_t        e;
        int          herr, derr, berr, rerr, gerr, idx;
        herr = 0; derr = 0; berr = 0; rerr = 0; gerr = 0;
        sb.push_back('{user: tu[inst], data: td[inst]});
        for (int j = 1; j <= 23 * cps; j++) begin
            @(negedge clk);
            idx = (j - 1) / cps;
            if (((j - 1) % cps) == 0) sym[idx] = tx[inst];
            else if (tx[inst] !== sym[idx]) herr++;
            if (dn[inst] !== (j == 23 * cps)) derr++;
            if (bz[inst] !== 1'b1) berr++;
            if (tr[inst] !== 1'b0) rerr++;
            if (j == 1) begin
                td[inst] = {6'($urandom), 32'($urandom)};
                tu[inst] = 2'($urandom);
                if (!hold_valid) tv[inst] = 1'b0;
            end
            if (pulse_at != 0 && j == pulse_at) tv[inst] = 1'b1;
            if (pulse_at != 0 && j == pulse_at + 1) tv[inst] = 1'b0;
        end
        for (int i = 0; i < 19; i++) dec[37-2*i -: 2] = sym[3+i];
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check("sof", {sym[0], sym[1]}, 4'b1110);
            check("user", sym[2], e.user);
            check("data", dec, e.data);
            check("parity", sym[22], model_par(e.user, e.data));
        end
        check("symbol_hold", herr, 0);
        check("tdone_timing", derr, 0);
        check("busy_in_frame", berr, 0);
        check("tready_in_frame", rerr, 0);
        for (int j = 1; j <= gap * cps; j++) begin
            @(negedge clk);
            if (tx[inst] !== 2'b00 || dn[inst] !== 1'b0 || bz[inst] !== 1'b1 || tr[inst] !== 1'b0)
                gerr++;
        end
        check("gap", gerr, 0);
    endtask

    initial begin
        bit ok;
        int t_prev, t_acc, errs;

        n_cmp = 0;
        n_mis = 0;
        rst   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lu[i] = 1'b1; tv[i] = 1'b0; td[i] = '0; tu[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_linktx", tx[i], 2'b00);
            check("rst_tready", tr[i], 1'b0);
            check("rst_tdone", dn[i], 1'b0);
            check("rst_busy", bz[i], 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check("tready_after_rst", tr[i], 1'b1);

        // Zero payload, command type, CPS=1 / GAP=2.
        td[0] = '0; tu[0] = 2'b01; tv[0] = 1'b1;
        wait_accept(0, 10, ok);
        if (ok) begin
            run_frame(0, 1, 2, 1'b0, 0);
            @(negedge clk);
            check("t1_tready_k26", tr[0], 1'b1);
            check("t1_busy_k26", bz[0], 1'b0);
        end

        // All-ones payload, sample type.
        td[0] = 38'h3F_FFFF_FFFF; tu[0] = 2'b10; tv[0] = 1'b1;
        wait_accept(0, 10, ok);
        if (ok) begin
            run_frame(0, 1, 2, 1'b0, 0);
            @(negedge clk);
            check("t2_tready", tr[0], 1'b1);
        end

        // Back-to-back random words, CPS=4: 101-cycle frame period.
        td[1] = {6'($urandom), 32'($urandom)}; tu[1] = 2'($urandom); tv[1] = 1'b1;
        wait_accept(1, 10, ok);
        t_prev = 0;
        for (int i = 0; i < 200 && ok; i++) begin
            t_acc = cyc;
            if (i > 0) check("period", t_acc - t_prev, 101);
            t_prev = t_acc;
            run_frame(1, 4, 2, 1'b1, 0);
            @(negedge clk);
            if (i == 199) tv[1] = 1'b0;
            else wait_accept(1, 4, ok);
        end
        @(negedge clk);

        // Reset during D7.
        td[1] = {6'($urandom), 32'($urandom)}; tu[1] = 2'($urandom); tv[1] = 1'b1;
        wait_accept(1, 10, ok);
        if (ok) begin
            errs = 0;
            for (int j = 1; j <= 42; j++) begin
                @(negedge clk);
                if (j == 1) tv[1] = 1'b0;
                if (dn[1] !== 1'b0) errs++;
            end
            rst = 1'b1;
            @(negedge clk);
            check("rst_mid_linktx", tx[1], 2'b00);
            check("rst_mid_tready", tr[1], 1'b0);
            check("rst_mid_busy", bz[1], 1'b0);
            check("rst_mid_tdone", dn[1], 1'b0);
            rst = 1'b0;
            for (int j = 0; j < 10; j++) begin
                @(negedge clk);
                if (dn[1] !== 1'b0 || tx[1] !== 2'b00) errs++;
            end
            check("rst_no_tdone", errs, 0);
        end
        td[1] = {6'($urandom), 32'($urandom)}; tu[1] = 2'($urandom); tv[1] = 1'b1;
        wait_accept(1, 10, ok);
        if (ok) run_frame(1, 4, 2, 1'b0, 0);
        @(negedge clk);

        // link_up drop during D3.
        td[1] = {6'($urandom), 32'($urandom)}; tu[1] = 2'($urandom); tv[1] = 1'b1;
        wait_accept(1, 10, ok);
        if (ok) begin
            errs = 0;
            for (int j = 1; j <= 26; j++) begin
                @(negedge clk);
                if (j == 1) tv[1] = 1'b0;
                if (dn[1] !== 1'b0) errs++;
            end
            lu[1] = 1'b0;
            for (int j = 1; j <= 8; j++) begin
                @(negedge clk);
                if (tx[1] !== 2'b00 || bz[1] !== 1'b1 || dn[1] !== 1'b0) errs++;
            end
            check("abort_gap", errs, 0);
            @(negedge clk);
            check("abort_idle_busy", bz[1], 1'b0);
            check("abort_idle_tready", tr[1], 1'b0);
            errs = 0;
            tv[1] = 1'b1;
            for (int j = 0; j < 5; j++) begin
                @(negedge clk);
                if (tr[1] !== 1'b0 || tx[1] !== 2'b00 || bz[1] !== 1'b0) errs++;
            end
            check("link_down_idle", errs, 0);
            tv[1] = 1'b0;
            lu[1] = 1'b1;
            @(negedge clk);
            check("link_up_tready", tr[1], 1'b1);
        end

        // Pulse while busy is ignored; GAP=0 returns to IDLE right after PAR.
        td[2] = {6'($urandom), 32'($urandom)}; tu[2] = 2'($urandom); tv[2] = 1'b1;
        wait_accept(2, 10, ok);
        if (ok) begin
            run_frame(2, 1, 0, 1'b0, 5);
            @(negedge clk);
            check("nogap_busy", bz[2], 1'b0);
            check("nogap_tready", tr[2], 1'b1);
            errs = 0;
            for (int j = 0; j < 30; j++) begin
                @(negedge clk);
                if (tx[2] !== 2'b00 || bz[2] !== 1'b0 || dn[2] !== 1'b0) errs++;
            end
            check("pulse_not_accepted", errs, 0);
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
